regfile_multiport: RTL and testbench

Parametrised successor to the core integer register file. It provides NRD combinational read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass. It also holds a per-register pending (busy) scoreboard that the decode stage sets on issue and writeback clears. It sits between decode (read, issue) and writeback (write), and supports a future dual-issue or pipelined RV32I core.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_multiport.sv | 86 ++++++++
 tb/tb_regfile_multiport.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and write-port arbitration helper for the multiport register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);
    localparam int unsigned NWR_MAX       = 4;

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

    // Highest-index set bit wins; callers gate on |hits for validity.
    function automatic logic [1:0] win_port(input logic [NWR_MAX-1:0] hits);
        logic [1:0] w;
        w = '0;
        for (int i = 0; i < int'(NWR_MAX); i++) begin
            if (hits[i]) w = 2'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: flush beats issue, issue set beats writeback clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_hit,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else begin
            for (int w = 0; w < int'(NWR); w++) begin
                if (wr_en[w]) pending_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
            if (iss_en) pending_d[iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_busy
        // A same-cycle writeback is seen as already complete when bypassing.
        assign rd_busy[i] = pending_q[rd_addr[i*AW +: AW]] & ~((BYPASS != 0) & rd_hit[i]);
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NRD combinational reads, NWR synchronous writes, optional bypass.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [NRD-1:0]  rd_hit;

    // Later ports overwrite earlier ones in loop order, so the highest index wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NREGS); r++) mem_q[r] <= '0;
        end else begin
            for (int w = 0; w < int'(NWR); w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] != '0) begin
                    mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0]      ra;
        logic [NWR_MAX-1:0] hits;
        logic [1:0]         win;
        logic [XLEN-1:0]    rdat;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            hits = '0;
            for (int w = 0; w < int'(NWR); w++) begin
                hits[w] = wr_en[w] && (wr_addr[w*AW +: AW] == ra) && (ra != '0);
            end
        end

        assign win       = win_port(hits);
        assign rd_hit[i] = |hits;

        always_comb begin
            if ((BYPASS != 0) && rd_hit[i]) rdat = wr_data[32'(win)*XLEN +: XLEN];
            else if (ra == '0)              rdat = '0;
            else                            rdat = mem_q[ra];
        end

        assign rd_data[i*XLEN +: XLEN] = rdat;
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_hit   (rd_hit),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: bypassing and non-bypassing instances share stimulus and a model.
module tb_regfile_multiport;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    regfile_multiport #(.NRD(2), .NWR(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
    );

    regfile_multiport #(.NRD(2), .NWR(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index of the last enabled port writing address a, or -1.
    function automatic int writer(input logic [4:0] a);
        int r = -1;
        if (a == 5'd0) return -1;
        for (int w = 0; w < 2; w++) begin
            if (wr_en[w] && wr_addr[w*5 +: 5] == a) r = w;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        int w = writer(a);
        if (a == 5'd0) return 32'h0;
        if (byp && w >= 0) return wr_data[w*32 +: 32];
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && writer(a) >= 0) return 32'h0;
        return {31'h0, m_pend[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ports();
        logic [4:0] a;
        for (int i = 0; i < 2; i++) begin
            a = rd_addr[i*5 +: 5];
            check($sformatf("byp_data%0d x%0d", i, a), rd_data_b[i*32 +: 32], exp_data(a, 1'b1));
            check($sformatf("nob_data%0d x%0d", i, a), rd_data_n[i*32 +: 32], exp_data(a, 1'b0));
            check($sformatf("byp_busy%0d x%0d", i, a), {31'h0, rd_busy_b[i]}, exp_busy(a, 1'b1));
            check($sformatf("nob_busy%0d x%0d", i, a), {31'h0, rd_busy_n[i]}, exp_busy(a, 1'b0));
        end
    endtask

    task automatic model_update();
        logic [4:0] a;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'h0;
                m_pend[r] = 1'b0;
            end
            return;
        end
        for (int w = 0; w < 2; w++) begin
            a = wr_addr[w*5 +: 5];
            if (wr_en[w] && a != 5'd0) m_regs[a] = wr_data[w*32 +: 32];
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (wr_en[w]) m_pend[wr_addr[w*5 +: 5]] = 1'b0;
            end
            if (iss_en && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
        end
    endtask

    // Inputs are set just after a falling edge; check, advance model, wait one cycle.
    task automatic tick();
        #1;
        check_ports();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; iss_en = 1'b0; iss_addr = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        idle();
        rd(5'd0, 5'd0);
        rst = 1'b1;
        #1;
        model_update();
        @(negedge clk);
        idle();

        // Reset state and basic write/read
        rd(5'd5, 5'd1);
        #1;
        check("reset_x5", rd_data_n[31:0], 32'h0);
        check("reset_busy", {30'h0, rd_busy_n}, 32'h0);
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        rd(5'd5, 5'd0);
        #1;
        check("x5_read", rd_data_n[31:0], 32'hDEADBEEF);
        check("x0_read", rd_data_n[63:32], 32'h0);
        tick();
        rst = 1'b1;
        tick();
        idle();
        #1;
        check("x5_after_rst", rd_data_b[31:0], 32'h0);
        tick();

        // Register 0 ignores writes and issue
        rd(5'd0, 5'd0);
        wr(0, 5'd0, 32'h12345678);
        iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        idle();
        #1;
        check("x0_data", rd_data_b[31:0], 32'h0);
        check("x0_busy", {31'h0, rd_busy_b[0]}, 32'h0);
        tick();

        // Same-cycle bypass vs stored value
        rd(5'd7, 5'd7);
        wr(0, 5'd7, 32'hA5A5A5A5);
        #1;
        check("byp_x7", rd_data_b[31:0], 32'hA5A5A5A5);
        check("nob_x7_old", rd_data_n[31:0], 32'h0);
        tick();
        idle();
        #1;
        check("nob_x7_next", rd_data_n[31:0], 32'hA5A5A5A5);
        tick();

        // Write conflict: highest port wins
        rd(5'd3, 5'd3);
        wr(0, 5'd3, 32'h1);
        wr(1, 5'd3, 32'h2);
        #1;
        check("conflict_byp", rd_data_b[31:0], 32'h2);
        tick();
        idle();
        #1;
        check("conflict_store", rd_data_n[31:0], 32'h2);
        tick();

        // Scoreboard issue / writeback ordering
        rd(5'd9, 5'd9);
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        #1;
        check("x9_busy", {31'h0, rd_busy_b[0]}, 32'h1);
        wr(0, 5'd9, 32'h99);
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        #1;
        check("x9_still_busy", {31'h0, rd_busy_n[0]}, 32'h1);
        wr(0, 5'd9, 32'h98);
        #1;
        check("x9_wb_byp_busy", {31'h0, rd_busy_b[0]}, 32'h0);
        check("x9_wb_nob_busy", {31'h0, rd_busy_n[0]}, 32'h1);
        tick();
        idle();
        #1;
        check("x9_cleared", {31'h0, rd_busy_n[0]}, 32'h0);
        tick();

        // Flush beats a same-cycle issue and leaves data alone
        for (int k = 1; k <= 3; k++) begin
            iss_en = 1'b1; iss_addr = 5'(4 * k);
            tick();
        end
        idle();
        rd(5'd4, 5'd8);
        #1;
        check("x4_pend", {31'h0, rd_busy_b[0]}, 32'h1);
        check("x8_pend", {31'h0, rd_busy_b[1]}, 32'h1);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        idle();
        rd(5'd6, 5'd12);
        #1;
        check("x6_not_pend", {31'h0, rd_busy_n[0]}, 32'h0);
        check("x12_flushed", {31'h0, rd_busy_n[1]}, 32'h0);
        tick();
        rd(5'd3, 5'd4);
        #1;
        check("x3_kept", rd_data_n[31:0], 32'h2);
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 11) == 0);
            for (int w = 0; w < 2; w++) begin
                if ($urandom_range(0, 2) != 0) wr(w, 5'($urandom_range(0, 7)), $urandom);
            end
            iss_en   = $urandom_range(0, 1) == 1;
            iss_addr = 5'($urandom_range(0, 7));
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 1) == 1) rd_addr[i*5 +: 5] = wr_addr[$urandom_range(0, 1)*5 +: 5];
                else                           rd_addr[i*5 +: 5] = 5'($urandom_range(0, 31));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
